// File: rtl/mtx_pkg.sv
// Shared definitions for the elementwise-multiply datapath: matrix geometry,
// element index helpers and the streamer state encoding.
package mtx_pkg;

    localparam int N_ROWS = 4;
    localparam int N_COLS = 4;
    localparam int N_ELEM = 16;
    localparam int IDX_W  = 4;

    localparam logic [IDX_W-1:0] IDX_FIRST = '0;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_ELEM - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } mtx_state_t;

    // Row-major flat index of element (row, col).
    function automatic logic [IDX_W-1:0] elemIdx(input int row, input int col);
        return IDX_W'(row * N_COLS + col);
    endfunction

endpackage

// File: rtl/mtx_requant_sat.sv
// Requantises one 2*W-bit product: logical right shift by SHIFT, then unsigned
// saturation to OUT_W bits. Purely combinational.
module mtx_requant_sat #(
    parameter int W     = 8,
    parameter int OUT_W = 2 * W,
    parameter int SHIFT = 0
) (
    input  logic [2*W-1:0]   elem_i,
    output logic [OUT_W-1:0] data_o
);

    logic [2*W-1:0] shifted;

    assign shifted = elem_i >> SHIFT;

    // Full-width output can never overflow, so the clamp only exists when narrowing.
    generate
        if (OUT_W == 2 * W) begin : gNoSat
            assign data_o = shifted;
        end else begin : gSat
            logic overflow;
            assign overflow = |shifted[2*W-1:OUT_W];
            assign data_o   = overflow ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];
        end
    endgenerate

endmodule

// File: rtl/mtx_result_streamer.sv
// Captures a flattened 4x4 product matrix in one handshake and streams its
// elements out row-major, one per beat, with optional requantisation.
module mtx_result_streamer
    import mtx_pkg::*;
#(
    parameter int W     = 8,
    parameter int OUT_W = 2 * W,
    parameter int SHIFT = 0
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [N_ELEM*2*W-1:0]   i_mtx_m,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic                    i_abort,
    output logic                    o_valid,
    output logic [OUT_W-1:0]        o_data,
    output logic [IDX_W-1:0]        o_idx,
    output logic                    o_last,
    input  logic                    i_ready
);

    mtx_state_t              state_q;
    logic [N_ELEM*2*W-1:0]   mtxBuf_q;
    logic [IDX_W-1:0]        idx_q;
    logic [IDX_W-1:0]        idx_d;
    logic [2*W-1:0]          curElem;

    assign idx_d   = idx_q + IDX_W'(1);
    assign curElem = mtxBuf_q[int'(idx_q) * (2 * W) +: 2 * W];

    // Load in IDLE (abort wins over valid); in STREAM advance on each beat and
    // fall back to IDLE after the last beat or on abort.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            mtxBuf_q <= '0;
            idx_q    <= IDX_FIRST;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid && !i_abort) begin
                        mtxBuf_q <= i_mtx_m;
                        idx_q    <= IDX_FIRST;
                        state_q  <= STREAM;
                    end
                end
                STREAM: begin
                    if (i_ready) begin
                        idx_q <= idx_d;
                    end
                    if (i_abort || (i_ready && idx_q == IDX_LAST)) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    mtx_requant_sat #(
        .W     (W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) uRequant (
        .elem_i (curElem),
        .data_o (o_data)
    );

    assign o_ready = (state_q == IDLE);
    assign o_valid = (state_q == STREAM);
    assign o_idx   = idx_q;
    assign o_last  = (state_q == STREAM) && (idx_q == IDX_LAST);

endmodule
